// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares the uart_controller transmit path among NREQ byte requesters.
// Optional launch timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int IDW           = 2,
  parameter int DW            = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk100mhz,
  input  logic                 cpu_reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 send_sig,
  output logic [DW-1:0]        send_data,
  input  logic                 busy_sending,
  output logic [IDW-1:0]       grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  if ((2**IDW) < NREQ || START_TIMEOUT < 2) begin : g_bad_params
    $error("uart_tx_arbiter: IDW too narrow for NREQ or START_TIMEOUT < 2");
  end

  state_t            r_state;
  logic [IDW-1:0]    r_last;
  logic [IDW-1:0]    r_grant;
  logic [DW-1:0]     r_data;
  logic              r_send;
  logic [NREQ-1:0]   r_ack;

  logic [DW-1:0]     w_bytes [NREQ];
  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic [IDW-1:0]    w_cand;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_bytes[g] = req_data[g*DW +: DW];
  end

  // Search starts just past the last winner so a held request waits at most NREQ-1 frames.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(START_TIMEOUT + 1);
  logic [CW-1:0] r_tcnt;
  logic          r_terr;
  assign timeout_err = r_terr;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk100mhz) begin
    if (cpu_reset) begin
      r_state <= S_IDLE;
      r_last  <= IDW'(NREQ - 1);
      r_grant <= '0;
      r_data  <= '0;
      r_send  <= 1'b0;
      r_ack   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_tcnt  <= '0;
      r_terr  <= 1'b0;
`endif
    end else begin
      r_send <= 1'b0;
      r_ack  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_terr <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!busy_sending && w_found) begin
            r_data  <= w_bytes[w_win];
            r_grant <= w_win;
            r_last  <= w_win;
            r_send  <= 1'b1;
            r_ack   <= NREQ'(1) << w_win;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          r_tcnt  <= '0;
`endif
        end
        S_WAIT_BUSY: begin
          if (busy_sending) begin
            r_state <= S_WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // LAUNCH cycle plus START_TIMEOUT-1 waiting cycles; pulse lands START_TIMEOUT after send_sig.
          else if (r_tcnt == CW'(START_TIMEOUT - 2)) begin
            r_state <= S_IDLE;
            r_terr  <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        S_WAIT_DONE: begin
          if (!busy_sending) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign send_sig  = r_send;
  assign ack       = r_ack;
  assign send_data = r_data;
  assign grant_id  = r_grant;
  assign arb_busy  = (r_state != S_IDLE);

endmodule
